mux2_rr_feeder: RTL and testbench

Two-source, valid/ready front end that arbitrates between two WIDTH-bit input channels and drives the select of the 2:1 datapath mux that follows it. Fair with a bounded burst. The selected word, together with the select bit that chose it, is registered into a single output stage. The downstream 2:1 mux netlist (`MUX_2_1`, SEL=1 picks the first IN operand) consumes `out_data` and `out_sel` directly. This block is the sequential stage that feeds that mux with a stable, registered select.

---
 rtl/mux2_rr_feeder.sv | 110 +++++++++++
 tb/tb_mux2_rr_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_feeder.sv
// mux2_rr_feeder
// ---------------------------------------------------------------------------
// Two-source valid/ready arbiter that feeds a registered 2:1 mux select.
// The arbiter is fair with a bounded burst: under contention, one source may
// win at most HOLD_MAX grants in a row before the other source is served.
// The granted word and the select bit that chose it are captured together in
// a single output register. The downstream MUX_2_1 consumes out_data and
// out_sel directly, so it always sees a stable select.
//
// Parameters:
//   WIDTH     data width of each channel
//   HOLD_MAX  max consecutive grants to one source while the other waits (1..15)
//
// Ports:
//   clk, rst_n                      rising-edge clock, async active-low reset
//   in1_valid/in1_ready/in1_data    source 1 channel (out_sel = 1)
//   in2_valid/in2_ready/in2_data    source 2 channel (out_sel = 0)
//   out_valid/out_ready/out_data    registered output channel
//   out_sel                         registered select of the held word
// ---------------------------------------------------------------------------
module mux2_rr_feeder #(
    parameter int WIDTH    = 2,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in2_valid,
    output logic             in2_ready,
    input  logic [WIDTH-1:0] in2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel
);

    typedef enum logic {
        SRC_IN2 = 1'b0,
        SRC_IN1 = 1'b1
    } src_e;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    src_e       last;       // source of the last accepted word
    logic [3:0] cnt;        // consecutive grants to 'last', saturates at HOLD_LIM
    logic       load;       // output register can take a word this cycle
    logic       stick;      // contention: stay with 'last' for another grant
    logic       grant_vld;
    src_e       grant_src;
    src_e       other_src;

    // NOTE: every signal written in this block is given a default first, so
    // no path through the if/else leaves one unassigned (no latch inferred).
    always_comb begin
        // Gating with rst_n keeps both readies low while reset is held,
        // even though the cleared register would otherwise accept a word.
        load      = rst_n && (!out_valid || out_ready);
        stick     = (cnt != 4'd0) && (cnt < HOLD_LIM);
        other_src = (last == SRC_IN1) ? SRC_IN2 : SRC_IN1;
        grant_vld = 1'b0;
        grant_src = SRC_IN2;
        if (load) begin
            if (in1_valid && in2_valid) begin
                grant_vld = 1'b1;
                // cnt == 0 (after reset) or saturated forces a switch.
                grant_src = stick ? last : other_src;
            end else if (in1_valid) begin
                grant_vld = 1'b1;
                grant_src = SRC_IN1;
            end else if (in2_valid) begin
                grant_vld = 1'b1;
                grant_src = SRC_IN2;
            end
        end
    end

    // Readies depend only on valids, out_ready and state, never on data.
    assign in1_ready = grant_vld && (grant_src == SRC_IN1);
    assign in2_ready = grant_vld && (grant_src == SRC_IN2);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
            last      <= SRC_IN2;
            cnt       <= 4'd0;
        end else if (grant_vld) begin
            out_valid <= 1'b1;
            out_data  <= (grant_src == SRC_IN1) ? in1_data : in2_data;
            out_sel   <= grant_src;
            if (grant_src == last) begin
                if (cnt < HOLD_LIM) begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                last <= grant_src;
                cnt  <= 4'd1;
            end
        end else if (load) begin
            // Drained with nothing to replace it; data and select hold.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_feeder.sv
// Self-checking bench for mux2_rr_feeder.
// A small arbitration model predicts each cycle's readies; every predicted
// grant pushes the expected {select, word} onto a scoreboard queue, which is
// popped and compared when the word shows up on the output register.
// Directed scenarios add fixed expected sequences on top of that.
module tb_mux2_rr_feeder;

    localparam int WIDTH    = 2;
    localparam int HOLD_MAX = 4;

    logic             clk;
    logic             rst_n;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic             in2_valid;
    logic             in2_ready;
    logic [WIDTH-1:0] in2_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;

    mux2_rr_feeder #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in2_valid (in2_valid),
        .in2_ready (in2_ready),
        .in2_data  (in2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             sel;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic m_valid;
    logic m_last;
    int   m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_cnt   = 0;
        q.delete();
    endtask

    // One clock cycle: drive inputs after the falling edge, check readies
    // against the model, then check the output register after the rising edge.
    task automatic step(input logic v1, input logic [WIDTH-1:0] d1,
                        input logic v2, input logic [WIDTH-1:0] d2,
                        input logic ordy);
        logic can_take;
        logic g_vld;
        logic g_sel;
        exp_t e;
        @(negedge clk);
        in1_valid = v1;
        in1_data  = d1;
        in2_valid = v2;
        in2_data  = d2;
        out_ready = ordy;
        #1;
        can_take = !m_valid || ordy;
        g_vld    = can_take && (v1 || v2);
        if (v1 && v2) begin
            // Burst in progress and not yet at the limit: keep the same source.
            if (m_cnt >= 1 && m_cnt < HOLD_MAX) g_sel = m_last;
            else                                 g_sel = !m_last;
        end else begin
            g_sel = v1;
        end
        check("in1_ready", 32'(in1_ready), 32'(g_vld && g_sel));
        check("in2_ready", 32'(in2_ready), 32'(g_vld && !g_sel));
        if (g_vld) begin
            e.sel  = g_sel;
            e.data = g_sel ? d1 : d2;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (g_vld) begin
            m_valid = 1'b1;
            if (g_sel == m_last) begin
                if (m_cnt < HOLD_MAX) m_cnt++;
            end else begin
                m_last = g_sel;
                m_cnt  = 1;
            end
        end else if (can_take) begin
            m_valid = 1'b0;
        end
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (g_vld) begin
            e = q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_sel", 32'(out_sel), 32'(e.sel));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset applied from time 0 with random inputs; checked before the
        // first rising edge at t=5.
        rst_n     = 1'b0;
        in1_valid = 1'b1;
        in2_valid = 1'b1;
        in1_data  = WIDTH'($urandom);
        in2_data  = WIDTH'($urandom);
        out_ready = 1'($urandom);
        model_reset();
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_sel",   32'(out_sel),   32'd0);
        check("rst_in1_ready", 32'(in1_ready), 32'd0);
        check("rst_in2_ready", 32'(in2_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source: in1 streams 0..3, one cycle after acceptance each.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, WIDTH'(i), 1'b0, '0, 1'b1);
            check("single_data", 32'(out_data), 32'(i));
            check("single_sel",  32'(out_sel),  32'd1);
        end
        step(1'b0, '0, 1'b0, '0, 1'b1);
        check("single_drain", 32'(out_valid), 32'd0);

        // Contention from reset: four in1 grants, four in2, then in1 again.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 2'd1, 1'b1, 2'd2, 1'b1);
            check("contend_sel", 32'(out_sel), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Late competitor: in1 alone saturates the counter, so in2 wins next
        // and keeps winning for three more grants.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'd3, 1'b0, '0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd3, 1'b1, 2'd0, 1'b1);
            check("late_sel", 32'(out_sel), (i < 4) ? 32'd0 : 32'd1);
        end

        // Backpressure: the held word 3 stays put, no ready while stalled.
        step(1'b1, 2'd3, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd1, 1'b1, 2'd2, 1'b0);
            check("bp_data",  32'(out_data),  32'd3);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        step(1'b1, 2'd1, 1'b1, 2'd2, 1'b1);
        check("bp_resume_valid", 32'(out_valid), 32'd1);

        // Random traffic, scoreboard only.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom), WIDTH'($urandom), 1'($urandom), WIDTH'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end

        // Mid-stream reset during contention with a word held.
        step(1'b1, 2'd1, 1'b1, 2'd2, 1'b1);
        step(1'b1, 2'd1, 1'b1, 2'd2, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data",  32'(out_data),  32'd0);
        check("mid_rst_out_sel",   32'(out_sel),   32'd0);
        check("mid_rst_in1_ready", 32'(in1_ready), 32'd0);
        check("mid_rst_in2_ready", 32'(in2_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'd1, 1'b1, 2'd2, 1'b1);
        check("post_rst_sel",  32'(out_sel),  32'd1);
        check("post_rst_data", 32'(out_data), 32'd1);

        check("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
